// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between the IFU and the LSU, one transaction in flight.
// Optional response timeout is compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic                ifu_rsp_err,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic                lsu_rsp_err,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("mem_bus_arbiter: TIMEOUT must be at least 1");
  end

  state_t state, state_nxt;
  owner_t owner, last_grant;
  logic   grant_ifu, grant_lsu;
  logic   req_fire, rsp_fire, timeout_fire, wait_done;

  // NOTE: always_comb assigns every output a default first so no path can infer a latch.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == S_IDLE) begin
      if (ifu_req_valid && lsu_req_valid) begin
        if (last_grant == OWN_IFU) grant_lsu = 1'b1;
        else                       grant_ifu = 1'b1;
      end else if (lsu_req_valid) begin
        grant_lsu = 1'b1;
      end else if (ifu_req_valid) begin
        grant_ifu = 1'b1;
      end
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;
  assign mem_req_valid = (state == S_REQ);
  assign req_fire      = (state == S_REQ) && mem_req_ready;
  // A response coinciding with the request handshake is still in REQ and is dropped here.
  assign rsp_fire      = (state == S_WAIT) && mem_rsp_valid;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                wait_cnt <= '0;
    else if (req_fire)         wait_cnt <= '0;
    else if (state == S_WAIT)  wait_cnt <= wait_cnt + CNT_W'(1);
  end

  // A real response in the expiry cycle takes priority over the timeout.
  assign timeout_fire = (state == S_WAIT) && !mem_rsp_valid && (wait_cnt == CNT_W'(TIMEOUT));
`else
  assign timeout_fire = 1'b0;
`endif

  assign wait_done = rsp_fire || timeout_fire;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_ifu || grant_lsu) state_nxt = S_REQ;
      S_REQ:   if (mem_req_ready)          state_nxt = S_WAIT;
      S_WAIT:  if (wait_done)              state_nxt = S_IDLE;
      default:                             state_nxt = S_IDLE;
    endcase
  end

  assign ifu_rsp_valid = wait_done && (owner == OWN_IFU);
  assign lsu_rsp_valid = wait_done && (owner == OWN_LSU);
  assign ifu_rsp_err   = timeout_fire && (owner == OWN_IFU);
  assign lsu_rsp_err   = timeout_fire && (owner == OWN_LSU);
  assign ifu_rdata     = (rsp_fire && (owner == OWN_IFU)) ? mem_rdata : '0;
  assign lsu_rdata     = (rsp_fire && (owner == OWN_LSU)) ? mem_rdata : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      owner      <= OWN_IFU;
      last_grant <= OWN_IFU;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_lsu) begin
        owner      <= OWN_LSU;
        last_grant <= OWN_LSU;
        mem_addr   <= lsu_addr;
        mem_wen    <= lsu_wen;
        mem_wdata  <= lsu_wdata;
        mem_wmask  <= lsu_wmask;
      end else if (grant_ifu) begin
        owner      <= OWN_IFU;
        last_grant <= OWN_IFU;
        mem_addr   <= ifu_addr;
        mem_wen    <= 1'b0;
        mem_wdata  <= '0;
        mem_wmask  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter: grant, round-robin, stall, stray responses, reset.
// The timeout scenario is exercised only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_bus_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

  logic              clk;
  logic              rst_n;
  logic              ifu_req_valid, ifu_req_ready;
  logic [ADDR_W-1:0] ifu_addr;
  logic              ifu_rsp_valid, ifu_rsp_err;
  logic [DATA_W-1:0] ifu_rdata;
  logic              lsu_req_valid, lsu_req_ready;
  logic [ADDR_W-1:0] lsu_addr;
  logic              lsu_wen;
  logic [DATA_W-1:0] lsu_wdata;
  logic [MASK_W-1:0] lsu_wmask;
  logic              lsu_rsp_valid, lsu_rsp_err;
  logic [DATA_W-1:0] lsu_rdata;
  logic              mem_req_valid, mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_err(ifu_rsp_err), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_err(lsu_rsp_err), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks happen 1 ns later, well before the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in IDLE with a grant pending: grant edge, handshake edge, one-cycle response.
  task automatic run_txn(input string tag, input logic exp_lsu, input logic [31:0] exp_addr);
    tick();
    #1;
    check({tag, " req_valid"}, 64'(mem_req_valid), 64'd1);
    check({tag, " addr"}, 64'(mem_addr), 64'(exp_addr));
    tick();
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h1234_5678;
    #1;
    check({tag, " lsu_rsp"}, 64'(lsu_rsp_valid), 64'(exp_lsu));
    check({tag, " ifu_rsp"}, 64'(ifu_rsp_valid), 64'(!exp_lsu));
    check({tag, " rdata"}, 64'(exp_lsu ? lsu_rdata : ifu_rdata), 64'h1234_5678);
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;

    // Reset state
    #2;
    check("rst mem_req_valid", 64'(mem_req_valid), 64'd0);
    check("rst readies", 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
    check("rst rsp", 64'({ifu_rsp_valid, lsu_rsp_valid, ifu_rsp_err, lsu_rsp_err}), 64'd0);
    check("rst mem regs", 64'({mem_wen, mem_wmask}) | 64'(mem_addr) | 64'(mem_wdata), 64'd0);
    #10 rst_n = 1'b1;
    tick();

    // 1: IFU alone, response two cycles after grant
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1;
    #1;
    check("t1 ifu_ready", 64'(ifu_req_ready), 64'd1);
    check("t1 lsu_ready", 64'(lsu_req_ready), 64'd0);
    tick();
    ifu_req_valid = 1'b0;
    #1;
    check("t1 req_valid", 64'(mem_req_valid), 64'd1);
    check("t1 mem_addr", 64'(mem_addr), 64'h8000_0000);
    check("t1 wen/wmask", 64'({mem_wen, mem_wmask}), 64'd0);
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0413;
    #1;
    check("t1 ifu_rsp", 64'(ifu_rsp_valid), 64'd1);
    check("t1 ifu_rdata", 64'(ifu_rdata), 64'h0000_0413);
    check("t1 lsu_rsp", 64'(lsu_rsp_valid), 64'd0);
    check("t1 err", 64'(ifu_rsp_err), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    check("t1 idle", 64'(mem_req_valid), 64'd0);

    // 2: tie after reset goes to LSU, then alternates
    rst_n = 1'b0; #2; rst_n = 1'b1;
    tick();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000; lsu_wen = 1'b0;
    #1;
    check("t2 tie1 lsu_ready", 64'(lsu_req_ready), 64'd1);
    check("t2 tie1 ifu_ready", 64'(ifu_req_ready), 64'd0);
    run_txn("t2 tie1", 1'b1, 32'h8000_2000);
    #1;
    check("t2 tie2 ifu_ready", 64'(ifu_req_ready), 64'd1);
    check("t2 tie2 lsu_ready", 64'(lsu_req_ready), 64'd0);
    run_txn("t2 tie2", 1'b0, 32'h8000_0100);
    #1;
    check("t2 tie3 lsu_ready", 64'(lsu_req_ready), 64'd1);
    run_txn("t2 tie3", 1'b1, 32'h8000_2000);
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

    // 3: LSU store held through a 3-cycle memory stall; changing inputs after grant has no effect
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011; mem_req_ready = 1'b0;
    tick();
    lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_wmask = 4'hF; lsu_wen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      // 4 (REQ half): a response while the request is still pending is ignored
      mem_rsp_valid = (i == 0);
      #1;
      check("t3 stall valid", 64'(mem_req_valid), 64'd1);
      check("t3 stall bus", {mem_addr, mem_wdata},  {32'h8000_1000, 32'hDEAD_BEEF});
      check("t3 stall ctl", 64'({mem_wen, mem_wmask}), 64'({1'b1, 4'b0011}));
      check("t3 stray rsp", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
      tick();
    end
    mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_rsp_valid = 1'b1;
    #1;
    check("t3 ack lsu", 64'(lsu_rsp_valid), 64'd1);
    check("t3 ack ifu", 64'(ifu_rsp_valid), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;

    // 4 (IDLE half): response with nothing outstanding
    mem_rsp_valid = 1'b1;
    #1;
    check("t4 idle rsp", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    #1;
    check("t4 still idle", 64'(mem_req_valid), 64'd0);

    // 5: reset while waiting, late response ignored, next fetch served
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
    tick();
    ifu_req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("t5 rst valid", 64'(mem_req_valid), 64'd0);
    check("t5 rst addr", 64'(mem_addr), 64'd0);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1;
    #1;
    check("t5 late rsp", 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0080;
    run_txn("t5 after rst", 1'b0, 32'h8000_0080);
    ifu_req_valid = 1'b0;

`ifdef MEM_ARB_TIMEOUT_EN
    // 6: no response; error strobe on the fourth cycle after entering WAIT
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000; lsu_wen = 1'b0;
    tick();
    lsu_req_valid = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t6 no early rsp", 64'(lsu_rsp_valid), 64'd0);
      tick();
    end
    #1;
    check("t6 to valid", 64'(lsu_rsp_valid), 64'd1);
    check("t6 to err", 64'(lsu_rsp_err), 64'd1);
    check("t6 to rdata", 64'(lsu_rdata), 64'd0);
    check("t6 ifu quiet", 64'({ifu_rsp_valid, ifu_rsp_err}), 64'd0);
    tick();
    mem_rsp_valid = 1'b1;
    #1;
    check("t6 late rsp", 64'({lsu_rsp_valid, lsu_rsp_err}), 64'd0);
    tick();
    mem_rsp_valid = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
